// File: rtl/gps_gprmc_parse.sv
// $GPRMC sentence parser: ASCII time/position/date fields to binary, committed on a valid fix.
// Optional checksum verification is enabled by defining GPRMC_CHECKSUM_EN.
module gps_gprmc_parse #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ok,
  output logic       getMegOk,
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic [7:0] latDu,
  output logic [7:0] latMin,
  output logic [7:0] longDu,
  output logic [7:0] longMin,
  output logic [7:0] day,
  output logic [7:0] mon,
  output logic [7:0] year,
  output logic       frame_err
);
  typedef enum logic [2:0] {IDLE, HDR, FLD, CHK, COMMIT, ABORT} state_t;
  state_t      state;
  logic        rx_q1, rx_q2, stb;
  logic [2:0]  hdr_idx;
  logic [3:0]  field, pos;
  logic        status_ok;
  logic [31:0] to_cnt;
  logic [7:0]  s_hour, s_min, s_sec, s_latdu, s_latmin, s_longdu, s_longmin, s_day, s_mon, s_year;
  logic [7:0]  d, hdr_c;
  logic        is_dig, is_eol, cap, short_fld;

  assign stb    = rx_q1 & ~rx_q2;
  assign d      = rx_data - 8'h30;
  assign is_dig = (rx_data >= "0") && (rx_data <= "9");
  assign is_eol = (rx_data == 8'h0d) || (rx_data == 8'h0a);

  function automatic logic [7:0] mac(input logic [7:0] a, input logic [7:0] dd);
    return a * 8'd10 + dd;
  endfunction

  always_comb begin
    hdr_c = "G";
    case (hdr_idx)
      3'd1:    hdr_c = "P";
      3'd2:    hdr_c = "R";
      3'd3:    hdr_c = "M";
      3'd4:    hdr_c = "C";
      default: hdr_c = "G";
    endcase
  end

  // Capture windows per field; a comma before the window is full is a short field.
  always_comb begin
    cap       = 1'b0;
    short_fld = 1'b0;
    case (field)
      4'd1:    begin cap = pos < 4'd6; short_fld = pos < 4'd6; end
      4'd3:    begin cap = pos < 4'd4; short_fld = pos < 4'd4; end
      4'd5:    begin cap = pos < 4'd5; short_fld = pos < 4'd5; end
      4'd9:    begin cap = pos < 4'd6; short_fld = pos < 4'd6; end
      default: begin cap = 1'b0;       short_fld = 1'b0;       end
    endcase
  end

`ifdef GPRMC_CHECKSUM_EN
  logic [7:0] xsum;
  logic [3:0] chk_hi, hex_nib;
  logic       chk_n, hex_ok;

  always_comb begin
    hex_ok  = 1'b1;
    hex_nib = rx_data[3:0];
    if (is_dig)                                       hex_nib = rx_data[3:0];
    else if (rx_data >= "A" && rx_data <= "F")        hex_nib = rx_data[3:0] + 4'd9;
    else if (rx_data >= "a" && rx_data <= "f")        hex_nib = rx_data[3:0] + 4'd9;
    else                                              hex_ok  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)                                  xsum <= 8'd0;
    else if (stb && rx_data == "$")           xsum <= 8'd0;
    else if (stb && (state == HDR || state == FLD) && rx_data != "*")
                                              xsum <= xsum ^ rx_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q1 <= 1'b1; rx_q2 <= 1'b1;
      state <= IDLE; hdr_idx <= 3'd0; field <= 4'd0; pos <= 4'd0;
      status_ok <= 1'b0; to_cnt <= 32'd0;
      s_hour <= 8'd0; s_min <= 8'd0; s_sec <= 8'd0; s_latdu <= 8'd0; s_latmin <= 8'd0;
      s_longdu <= 8'd0; s_longmin <= 8'd0; s_day <= 8'd0; s_mon <= 8'd0; s_year <= 8'd0;
      hour <= 8'd0; min <= 8'd0; sec <= 8'd0; latDu <= 8'd0; latMin <= 8'd0;
      longDu <= 8'd0; longMin <= 8'd0; day <= 8'd0; mon <= 8'd0; year <= 8'd0;
      getMegOk <= 1'b0; frame_err <= 1'b0;
`ifdef GPRMC_CHECKSUM_EN
      chk_hi <= 4'd0; chk_n <= 1'b0;
`endif
    end else begin
      rx_q1     <= rx_ok;
      rx_q2     <= rx_q1;
      frame_err <= 1'b0;
      to_cnt    <= (stb || state == IDLE) ? 32'd0 : to_cnt + 32'd1;
      case (state)
        IDLE: if (stb && rx_data == "$") begin state <= HDR; hdr_idx <= 3'd0; end
        COMMIT: begin
          if (status_ok) begin
            hour <= s_hour; min <= s_min; sec <= s_sec; latDu <= s_latdu; latMin <= s_latmin;
            longDu <= s_longdu; longMin <= s_longmin; day <= s_day; mon <= s_mon; year <= s_year;
            getMegOk <= 1'b1;
          end
          state <= IDLE;
        end
        ABORT: begin frame_err <= 1'b1; state <= IDLE; end
        HDR, FLD, CHK: begin
          if (!stb) begin
            if (to_cnt == TIMEOUT_CYCLES - 32'd1) state <= ABORT;
          end else if (rx_data == "$") begin
            // Resync: drop the partial sentence and start matching the new header now.
            frame_err <= 1'b1; state <= HDR; hdr_idx <= 3'd0;
          end else if (is_eol) begin
            state <= ABORT;
          end else begin
            case (state)
              HDR: begin
                if (hdr_idx == 3'd5) begin
                  if (rx_data == ",") begin state <= FLD; field <= 4'd1; pos <= 4'd0; end
                  else state <= IDLE;
                end else if (rx_data == hdr_c) begin
                  hdr_idx <= hdr_idx + 3'd1;
                  if (hdr_idx == 3'd4) begin getMegOk <= 1'b0; status_ok <= 1'b0; end
                end else state <= IDLE;
              end
              FLD: begin
                if (rx_data == ",") begin
                  if (short_fld || field == 4'd12) state <= ABORT;
                  else begin field <= field + 4'd1; pos <= 4'd0; end
                end else if (rx_data == "*") begin
                  if (field < 4'd9) state <= ABORT;
`ifdef GPRMC_CHECKSUM_EN
                  else begin state <= CHK; chk_n <= 1'b0; end
`else
                  else state <= COMMIT;
`endif
                end else if (cap && !is_dig) begin
                  state <= ABORT;
                end else begin
                  if (pos != 4'd15) pos <= pos + 4'd1;
                  if (field == 4'd2 && pos == 4'd0 && rx_data == "A") status_ok <= 1'b1;
                  case (field)
                    4'd1: case (pos)
                      4'd0: s_hour <= d;  4'd1: s_hour <= mac(s_hour, d);
                      4'd2: s_min  <= d;  4'd3: s_min  <= mac(s_min, d);
                      4'd4: s_sec  <= d;  4'd5: s_sec  <= mac(s_sec, d);
                      default: ;
                    endcase
                    4'd3: case (pos)
                      4'd0: s_latdu  <= d;  4'd1: s_latdu  <= mac(s_latdu, d);
                      4'd2: s_latmin <= d;  4'd3: s_latmin <= mac(s_latmin, d);
                      default: ;
                    endcase
                    4'd5: case (pos)
                      4'd0: s_longdu  <= d;
                      4'd1, 4'd2: s_longdu <= mac(s_longdu, d);
                      4'd3: s_longmin <= d;  4'd4: s_longmin <= mac(s_longmin, d);
                      default: ;
                    endcase
                    4'd9: case (pos)
                      4'd0: s_day  <= d;  4'd1: s_day  <= mac(s_day, d);
                      4'd2: s_mon  <= d;  4'd3: s_mon  <= mac(s_mon, d);
                      4'd4: s_year <= d;  4'd5: s_year <= mac(s_year, d);
                      default: ;
                    endcase
                    default: ;
                  endcase
                end
              end
`ifdef GPRMC_CHECKSUM_EN
              CHK: begin
                if (!hex_ok) state <= ABORT;
                else if (!chk_n) begin chk_hi <= hex_nib; chk_n <= 1'b1; end
                else state <= ({chk_hi, hex_nib} == xsum) ? COMMIT : ABORT;
              end
`endif
              default: state <= IDLE;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
